reg_writeback_unit: RTL and testbench

//  Write-side owner of the 8x16 register file. Arbitrates ALU and load results onto the single RF write port.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_arbiter.sv | 37 +++
 rtl/reg_writeback_unit.sv | 120 ++++++++++++
 tb/tb_reg_writeback_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// the hard-wired zero register index and the writeback source encoding.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;
    localparam int R0        = 0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter.sv
// Chooses which result owns the RF write port this cycle: loads by default,
// the ALU when no load is waiting or after STARVE_MAX consecutive losses.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    alu_valid,
    input  logic    ld_valid,
    output wb_src_e grant
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q;

    always_comb begin
        grant = SRC_NONE;
        if (ld_valid && !(alu_valid && starve_q == SW'(STARVE_MAX)))
            grant = SRC_LD;
        else if (alu_valid)
            grant = SRC_ALU;
    end

    // Counts only cycles where the ALU was waiting and lost to a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_q <= '0;
        else if (!alu_valid || grant == SRC_ALU)
            starve_q <= '0;
        else if (grant == SRC_LD)
            starve_q <= starve_q + 1'b1;
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side owner of the register file: arbitrates ALU/load results onto the
// single RF write port and tracks in-flight writes per register for RAW stalls.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int CNT_W      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic                 issue_ready,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 ld_valid,
    input  logic [ADDR_W-1:0]    ld_rd,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_rw,
    output logic [DATA_W-1:0]    rf_busw,
    input  logic [ADDR_W-1:0]    chk_ra,
    input  logic [ADDR_W-1:0]    chk_rb,
    output logic                 chk_stall,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 wb_err
);

    localparam int               NREG    = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_src_e           grant;
    logic              acc;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;
    logic [NREG-1:0]   inc;
    logic [NREG-1:0]   dec;
    logic              err_set;
    logic [CNT_W-1:0]  cnt_q [NREG];

    wb_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .ld_valid  (ld_valid),
        .grant     (grant)
    );

    assign alu_ready = rst_n && (grant == SRC_ALU);
    assign ld_ready  = rst_n && (grant == SRC_LD);

    always_comb begin
        acc      = alu_ready || ld_ready;
        acc_rd   = ld_ready ? ld_rd   : alu_rd;
        acc_data = ld_ready ? ld_data : alu_data;
    end

    // R0 results are consumed normally but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_rw   <= '0;
            rf_busw <= '0;
        end else begin
            rf_we <= acc && (acc_rd != ADDR_W'(R0));
            if (acc && (acc_rd != ADDR_W'(R0))) begin
                rf_rw   <= acc_rd;
                rf_busw <= acc_data;
            end
        end
    end

    // A saturated destination may still issue when its write retires this cycle.
    assign issue_ready = rst_n &&
                         (!(issue_valid && cnt_q[issue_rd] == CNT_MAX) ||
                          (rf_we && rf_rw == issue_rd));

    always_comb begin
        inc     = '0;
        dec     = '0;
        err_set = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            inc[i] = issue_valid && issue_ready && (issue_rd == ADDR_W'(i));
            dec[i] = rf_we && (rf_rw == ADDR_W'(i));
            if (dec[i] && !inc[i] && cnt_q[i] == '0)
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= '0;
            wb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc[i] && !dec[i])
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (dec[i] && !inc[i] && cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - 1'b1;
            end
            wb_err <= wb_err || err_set;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++)
            pending[i] = (cnt_q[i] != '0);
    end

    assign chk_stall = pending[chk_ra] || pending[chk_rb];

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: handshake, arbitration with starvation
// relief, write-port timing, scoreboard saturation, R0 handling and sticky error.
module tb_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [2:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [2:0]  ld_rd;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        rf_we;
    logic [2:0]  rf_rw;
    logic [15:0] rf_busw;
    logic [2:0]  chk_ra;
    logic [2:0]  chk_rb;
    logic        chk_stall;
    logic [7:0]  pending;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_writeback_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .rf_we       (rf_we),
        .rf_rw       (rf_rw),
        .rf_busw     (rf_busw),
        .chk_ra      (chk_ra),
        .chk_rb      (chk_rb),
        .chk_stall   (chk_stall),
        .pending     (pending),
        .wb_err      (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0; issue_rd = 3'd0;
        alu_valid   = 1'b1; alu_rd   = 3'd1; alu_data = 16'h0;
        ld_valid    = 1'b1; ld_rd    = 3'd2; ld_data  = 16'h0;
        chk_ra      = 3'd0; chk_rb   = 3'd0;
        tick(); tick();
        chk("rst_rf_we",     32'(rf_we),     32'd0);
        chk("rst_rf_rw",     32'(rf_rw),     32'd0);
        chk("rst_rf_busw",   32'(rf_busw),   32'd0);
        chk("rst_pending",   32'(pending),   32'h00);
        chk("rst_wb_err",    32'(wb_err),    32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_ld_ready",  32'(ld_ready),  32'd0);
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // ALU writeback to R3 with stall tracking
        issue_valid = 1'b1; issue_rd = 3'd3; chk_ra = 3'd3;
        #1 chk("t2_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        #1 chk("t2_pending_set", 32'(pending),   32'h08);
        chk("t2_stall_pre",      32'(chk_stall), 32'd1);
        alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h0005;
        #1 chk("t2_alu_ready",   32'(alu_ready), 32'd1);
        chk("t2_ld_ready",       32'(ld_ready),  32'd0);
        tick();
        alu_valid = 1'b0;
        #1 chk("t2_rf_we",       32'(rf_we),     32'd1);
        chk("t2_rf_rw",          32'(rf_rw),     32'd3);
        chk("t2_rf_busw",        32'(rf_busw),   32'h0005);
        chk("t2_stall_during",   32'(chk_stall), 32'd1);
        tick();
        chk("t2_rf_we_clr",      32'(rf_we),     32'd0);
        chk("t2_pending_clr",    32'(pending),   32'h00);
        chk("t2_stall_post",     32'(chk_stall), 32'd0);

        // Arbitration: LD,LD,LD then forced ALU
        issue_valid = 1'b1; issue_rd = 3'd2;
        tick(); tick(); tick();
        issue_rd = 3'd1;
        tick();
        issue_valid = 1'b0;
        #1 chk("t3_pending",     32'(pending),   32'h06);
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h1111;
        ld_valid  = 1'b1; ld_rd  = 3'd2; ld_data  = 16'h2000;
        #1 chk("t3_c0_ld_ready", 32'(ld_ready),  32'd1);
        chk("t3_c0_alu_ready",   32'(alu_ready), 32'd0);
        tick();
        ld_data = 16'h2001;
        #1 chk("t3_c1_rf_we",    32'(rf_we),     32'd1);
        chk("t3_c1_rf_rw",       32'(rf_rw),     32'd2);
        chk("t3_c1_busw",        32'(rf_busw),   32'h2000);
        chk("t3_c1_ld_ready",    32'(ld_ready),  32'd1);
        chk("t3_c1_alu_ready",   32'(alu_ready), 32'd0);
        tick();
        ld_data = 16'h2002;
        #1 chk("t3_c2_busw",     32'(rf_busw),   32'h2001);
        chk("t3_c2_ld_ready",    32'(ld_ready),  32'd1);
        chk("t3_c2_alu_ready",   32'(alu_ready), 32'd0);
        tick();
        ld_data = 16'h2003;
        issue_valid = 1'b1; issue_rd = 3'd2;
        #1 chk("t3_c3_busw",     32'(rf_busw),   32'h2002);
        chk("t3_c3_alu_ready",   32'(alu_ready), 32'd1);
        chk("t3_c3_ld_ready",    32'(ld_ready),  32'd0);
        chk("t3_c3_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        alu_valid = 1'b0; issue_valid = 1'b0;
        #1 chk("t3_c4_rf_rw",    32'(rf_rw),     32'd1);
        chk("t3_c4_busw",        32'(rf_busw),   32'h1111);
        chk("t3_c4_ld_ready",    32'(ld_ready),  32'd1);
        tick();
        ld_valid = 1'b0;
        #1 chk("t3_c5_rf_rw",    32'(rf_rw),     32'd2);
        chk("t3_c5_busw",        32'(rf_busw),   32'h2003);
        tick();
        chk("t3_pending_drain",  32'(pending),   32'h00);
        chk("t3_wb_err",         32'(wb_err),    32'd0);

        // R0: accepted but never written, never pending
        issue_valid = 1'b1; issue_rd = 3'd0; chk_ra = 3'd0;
        #1 chk("t4_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'hBEEF;
        #1 chk("t4_alu_ready",   32'(alu_ready), 32'd1);
        chk("t4_pending_issue",  32'(pending),   32'h00);
        tick();
        alu_valid = 1'b0;
        #1 chk("t4_rf_we",       32'(rf_we),     32'd0);
        chk("t4_pending",        32'(pending),   32'h00);
        chk("t4_stall",          32'(chk_stall), 32'd0);
        tick();

        // Saturation on R5 and issue-through-retire
        issue_valid = 1'b1; issue_rd = 3'd5;
        tick(); tick(); tick();
        alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 16'h0055;
        #1 chk("t5_pending",     32'(pending),     32'h20);
        chk("t5_issue_ready_sat", 32'(issue_ready), 32'd0);
        chk("t5_alu_ready",      32'(alu_ready),   32'd1);
        tick();
        alu_valid = 1'b0;
        #1 chk("t5_rf_we",       32'(rf_we),       32'd1);
        chk("t5_rf_rw",          32'(rf_rw),       32'd5);
        chk("t5_issue_ready_retire", 32'(issue_ready), 32'd1);
        tick();
        chk("t5_issue_ready_still_sat", 32'(issue_ready), 32'd0);
        chk("t5_pending_hold",   32'(pending),     32'h20);
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        tick(); tick(); tick();
        alu_valid = 1'b0;
        tick();
        chk("t5_pending_drain",  32'(pending),     32'h00);
        chk("t5_wb_err",         32'(wb_err),      32'd0);

        // Writeback without issue: write happens, sticky error
        alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 16'h0066;
        #1 chk("t6_alu_ready",   32'(alu_ready),   32'd1);
        tick();
        alu_valid = 1'b0;
        #1 chk("t6_rf_we",       32'(rf_we),       32'd1);
        chk("t6_rf_rw",          32'(rf_rw),       32'd6);
        chk("t6_rf_busw",        32'(rf_busw),     32'h0066);
        chk("t6_wb_err_pre",     32'(wb_err),      32'd0);
        tick();
        chk("t6_wb_err_set",     32'(wb_err),      32'd1);
        chk("t6_pending",        32'(pending),     32'h00);
        issue_valid = 1'b1; issue_rd = 3'd7;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 16'h0077;
        tick();
        alu_valid = 1'b0;
        tick(); tick();
        chk("t6_wb_err_sticky",  32'(wb_err),      32'd1);
        chk("t6_pending_clean",  32'(pending),     32'h00);

        // Asynchronous reset in the middle of traffic
        issue_valid = 1'b1; issue_rd = 3'd4;
        tick();
        issue_valid = 1'b0;
        ld_valid  = 1'b1; ld_rd  = 3'd4; ld_data  = 16'h4444;
        alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 16'h7777;
        tick();
        chk("t1_pre_rf_we",      32'(rf_we),       32'd1);
        chk("t1_pre_pending",    32'(pending),     32'h10);
        rst_n = 1'b0;
        #1 chk("t1_rf_we",       32'(rf_we),       32'd0);
        chk("t1_rf_rw",          32'(rf_rw),       32'd0);
        chk("t1_rf_busw",        32'(rf_busw),     32'd0);
        chk("t1_pending",        32'(pending),     32'h00);
        chk("t1_wb_err",         32'(wb_err),      32'd0);
        chk("t1_alu_ready",      32'(alu_ready),   32'd0);
        chk("t1_ld_ready",       32'(ld_ready),    32'd0);
        ld_valid = 1'b0; alu_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
